// File: rtl/aq_djpeg_outbuf.sv
// aq_djpeg_outbuf: pixel output FIFO between the JPEG decoder colour stage
// and a valid/ready pixel sink. Each entry carries colour plus frame markers
// (start of frame, end of line, end of frame) computed when the pixel is
// written.
//
// Optional build macro: AQ_DJPEG_OUTBUF_RGB565_EN
//   defined   -> pixels are packed to RGB565 at write time, entries narrow to
//                16+3 bits and OutData[23:16] reads as zero
//   undefined -> OutData = {R,G,B}
//
// The FIFO head is presented combinationally, so OutValid is simply
// "occupancy non-zero". A pixel written into an empty FIFO is therefore
// visible in the cycle after its InEnable strobe, and Level counts every
// pixel not yet handed to the sink.
module aq_djpeg_outbuf #(
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ImageEnable,
  input  logic                  InEnable,
  input  logic [15:0]           InWidth,
  input  logic [15:0]           InHeight,
  input  logic [15:0]           InPixelX,
  input  logic [15:0]           InPixelY,
  input  logic [7:0]            InR,
  input  logic [7:0]            InG,
  input  logic [7:0]            InB,
  output logic                  InAlmostFull,
  output logic                  Overflow,
  output logic [DEPTH_LOG2:0]   Level,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [23:0]           OutData,
  output logic                  OutSof,
  output logic                  OutEol,
  output logic                  OutEof,
  output logic                  Busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef AQ_DJPEG_OUTBUF_RGB565_EN
  localparam int CW = 16;
`else
  localparam int CW = 24;
`endif
  localparam int EW = CW + 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state, state_next;

  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         wr_entry;
  logic [EW-1:0]         rd_entry;
  logic [CW-1:0]         pix;
  logic                  sof, eol, eof;
  logic                  ie_q, ie_rise;
  logic                  full, empty;
  logic                  wr_req, wr_en, rd_en, drop;
  logic                  drain_done;
  logic                  ovf;

  // Colour packing and frame-marker generation for the incoming pixel
  always_comb begin
`ifdef AQ_DJPEG_OUTBUF_RGB565_EN
    pix = {InR[7:3], InG[7:2], InB[7:3]};
`else
    pix = {InR, InG, InB};
`endif
    sof      = (InPixelX == 16'd0) && (InPixelY == 16'd0);
    eol      = (InPixelX == InWidth - 16'd1);
    eof      = eol && (InPixelY == InHeight - 16'd1);
    wr_entry = {pix, sof, eol, eof};
  end

`ifdef AQ_DJPEG_OUTBUF_RGB565_EN
  logic unused_low_bits;
  assign unused_low_bits = ^{InR[2:0], InG[1:0], InB[2:0]};
`endif

  // Occupancy, full/empty and transfer qualification
  always_comb begin
    level   = wr_ptr - rd_ptr;
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
              (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    rd_en   = !empty && OutReady;
    wr_req  = (state == RUN) && InEnable;
    // when full, a write only fits if the head leaves in the same cycle
    wr_en   = wr_req && (!full || rd_en);
    drop    = wr_req && full && !rd_en;
    ie_rise = ImageEnable && !ie_q;
    drain_done = empty || (rd_en && (level == {{DEPTH_LOG2{1'b0}}, 1'b1}));
  end

  // Output view of the FIFO head; zero whenever nothing is pending
  always_comb begin
    rd_entry = mem[rd_ptr[DEPTH_LOG2-1:0]];
    OutValid = !empty;
    OutData  = '0;
    OutSof   = 1'b0;
    OutEol   = 1'b0;
    OutEof   = 1'b0;
    if (!empty) begin
`ifdef AQ_DJPEG_OUTBUF_RGB565_EN
      OutData = {8'h00, rd_entry[EW-1 -: CW]};
`else
      OutData = rd_entry[EW-1 -: CW];
`endif
      OutSof  = rd_entry[2];
      OutEol  = rd_entry[1];
      OutEof  = rd_entry[0];
    end
  end

  // Status outputs
  always_comb begin
    Level        = level;
    Overflow     = ovf;
    Busy         = (state != IDLE);
    InAlmostFull = ((DEPTH - int'(level)) <= AFULL_MARGIN);
  end

  // Next-state logic for the image phase controller
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (ImageEnable) state_next = RUN;
      RUN:   if (!ImageEnable) state_next = FLUSH;
      // leave as the last pending pixel is taken, not one cycle later
      FLUSH: begin
        if (ImageEnable)     state_next = RUN;
        else if (drain_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Read/write pointers with an extra wrap bit for full/empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage; contents are meaningless while unoccupied, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_entry;
  end

  // Sticky overflow, cleared on a new image phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      ie_q <= 1'b0;
    end else begin
      ie_q <= ImageEnable;
      if (drop)         ovf <= 1'b1;
      else if (ie_rise) ovf <= 1'b0;
    end
  end

endmodule

// File: doc/aq_djpeg_outbuf.md
AQ_DJPEG_OUTBUF -- requirements
Module: aq_djpeg_outbuf

Interface
REQ-001 SHALL take parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 pixel entries.
REQ-002 SHALL take parameter AFULL_MARGIN, default 4: InAlmostFull asserts when free entries <= AFULL_MARGIN.
REQ-003 SHALL provide these ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- ImageEnable  in  1  decoder image phase active
- InEnable  in  1  pixel strobe from the decoder colour stage
- InWidth, InHeight  in  16 each  image size in pixels
- InPixelX, InPixelY  in  16 each  pixel coordinates
- InR, InG, InB  in  8 each  pixel colour
- InAlmostFull  out  1  free entries <= AFULL_MARGIN
- Overflow  out  1  sticky; a pixel was dropped
- Level  out  DEPTH_LOG2+1  FIFO occupancy
- OutValid  out  1  OutData is valid
- OutReady  in  1  sink accepts the data
- OutData  out  24  pixel, {R,G,B}
- OutSof, OutEol, OutEof  out  1 each  frame-start, line-end, frame-end markers
- Busy  out  1  state is not IDLE

Function
REQ-004 SHALL use three states: IDLE, RUN, FLUSH.
REQ-005 SHALL move IDLE->RUN on ImageEnable=1; in IDLE it SHALL ignore InEnable.
REQ-006 SHALL move RUN->FLUSH when ImageEnable falls.
REQ-007 SHALL move FLUSH->IDLE in the cycle Level reaches 0 with no pending OutValid.
REQ-008 SHALL move FLUSH->RUN if ImageEnable returns before the drain completes; FIFO contents SHALL be kept.
REQ-009 SHALL write one entry per InEnable cycle in RUN; the entry holds 24-bit colour plus 3 marker bits.
REQ-010 SHALL compute the markers at write time:
- Sof = (X==0 && Y==0)
- Eol = (X==InWidth-1)
- Eof = Eol && (Y==InHeight-1)
- compares are 16-bit unsigned
REQ-011 SHALL give a written pixel a latency of exactly 1 cycle to OutValid when the FIFO was empty and no output was pending.
REQ-012 SHALL complete an output transfer on OutValid && OutReady.
REQ-013 SHALL hold OutData and all markers stable while OutValid=1 and OutReady=0.
REQ-014 SHALL NOT drop OutValid until the transfer completes.
REQ-015 SHALL accept a write when full if a read completes in the same cycle; Level is then unchanged.
REQ-016 SHALL handle a write when full with no read as follows: pixel dropped, Overflow set, FIFO contents unchanged.
REQ-017 SHALL clear Overflow only on reset or a rising edge of ImageEnable.
REQ-018 SHALL keep Level exact under simultaneous write and read; Level SHALL never exceed 2**DEPTH_LOG2.
REQ-019 SHALL wrap read and write pointers modulo 2**DEPTH_LOG2, with an extra MSB for full/empty.
REQ-020 SHALL make InAlmostFull combinational from Level; it is advisory only and SHALL NOT gate writes.

Reset
REQ-021 SHALL force on rst, asynchronously:
- state=IDLE, pointers=0, Level=0, Overflow=0
- OutValid=0, OutData=0, OutSof=OutEol=OutEof=0, Busy=0
- InAlmostFull=0 (or 1 if AFULL_MARGIN >= 2**DEPTH_LOG2)
REQ-022 SHALL discard FIFO contents on reset mid-operation; no partial output SHALL appear after deassertion.

Configuration
REQ-023 SHALL pack output as RGB565 when macro AQ_DJPEG_OUTBUF_RGB565_EN is defined:
- OutData[15:0] = {R[7:3],G[7:2],B[7:3]}
- OutData[23:16] = 0
- packing done at write; FIFO entry narrows to 16+3 bits
REQ-024 SHALL pass OutData={R,G,B} unmodified when the macro is undefined.

Verification
REQ-025 Single pixel: reset; ImageEnable=1; one InEnable with X=0,Y=0, RGB=12/34/56, OutReady=1 -> next cycle OutValid=1, OutData=0x123456, OutSof=1.
REQ-026 Backpressure: 4x4 image, OutReady=0 for 10 cycles -> OutData stable across the stall; pixels emerge in order; OutEol on X=3; OutEof only on (3,3).
REQ-027 Overflow: DEPTH_LOG2=2, OutReady=0, 5 writes -> Level=4, Overflow=1, 5th pixel absent; new ImageEnable rising edge -> Overflow=0.
REQ-028 Full plus simultaneous read: full FIFO, OutReady=1 and InEnable in the same cycle -> write accepted, Level stays 4, Overflow=0.
REQ-029 Flush: ImageEnable falls with Level=3 -> Busy=1 until 3 transfers complete, then state=IDLE; rst asserted mid-flush -> OutValid=0 immediately.
REQ-030 RGB565 build: pixel 0xFF8040 -> OutData=0x00FC08.
